// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller and its timer.
package seg_pkg;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_t;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  // Counter width able to hold max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; expire is high while the count sits at zero (last count).
module scan_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic [CNT_W-1:0] reload_val,
  output logic             expire,
  output logic             expire_next
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (reload) begin
      count_next = reload_val;
    end else if (count_reg != '0) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expire      = (count_reg == '0);
  assign expire_next = (count_next == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller feeding a shared BCD-to-7-segment decoder with a
// double-buffered digit frame, per-digit on-time and inter-digit blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       err_in,
  output logic [BCD_W-1:0]            bcd_out,
  output logic                        err_out,
  output logic [NUM_DIGITS-1:0]       dig_en,
  output logic                        frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = cnt_width((DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BCD_W-1:0] BCD_LIMIT  = BCD_W'(BCD_MAX);

  scan_state_t                  state_reg, state_next;
  logic [IDX_W-1:0]             idx_reg, idx_next;
  logic                         armed_reg;
  logic [BCD_W*NUM_DIGITS-1:0]  pend_dig_reg, act_dig_reg, act_dig_next;
  logic [NUM_DIGITS-1:0]        pend_err_reg, act_err_reg, act_err_next;
  logic [BCD_W-1:0]             bcd_reg, bcd_next;
  logic                         err_reg, err_next;
  logic [NUM_DIGITS-1:0]        dig_en_reg, dig_en_next;
  logic                         frame_done_reg, frame_done_next;

  logic                         reload;
  logic [CNT_W-1:0]             reload_val;
  logic                         expire, expire_next;
  logic                         commit;
  logic [BCD_W-1:0]             nib [NUM_DIGITS];
  logic [BCD_W-1:0]             show_nib;

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .reload      (reload),
    .reload_val  (reload_val),
    .expire      (expire),
    .expire_next (expire_next)
  );

  // The first edge out of reset arms the timer, so the blanking gap after reset
  // is a full BLANK_CYCLES long, exactly like every other gap.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    reload     = 1'b0;
    reload_val = BLANK_LOAD;
    if (!armed_reg) begin
      reload = 1'b1;
    end else if (expire) begin
      reload = 1'b1;
      if (state_reg == SCAN_BLANK) begin
        state_next = SCAN_SHOW;
        reload_val = DIV_LOAD;
      end else begin
        state_next = SCAN_BLANK;
        idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
      end
    end
  end

  // Frame boundary: active swaps only here, with a same-cycle load bypassing pending.
  assign commit = armed_reg && (state_reg == SCAN_BLANK) && expire && (idx_reg == '0);

  always_comb begin
    act_dig_next = act_dig_reg;
    act_err_next = act_err_reg;
    if (commit) begin
      act_dig_next = load ? digits_in : pend_dig_reg;
      act_err_next = load ? err_in    : pend_err_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi]         = act_dig_next[gi*BCD_W +: BCD_W];
    assign dig_en_next[gi] = (state_next == SCAN_SHOW) && (idx_next == IDX_W'(gi));
  end

  assign show_nib = nib[idx_next];

  always_comb begin
    bcd_next        = '0;
    err_next        = 1'b0;
    frame_done_next = 1'b0;
    if (state_next == SCAN_SHOW) begin
      bcd_next        = show_nib;
      err_next        = act_err_next[idx_next] || (show_nib > BCD_LIMIT);
      frame_done_next = (idx_next == LAST_IDX) && expire_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= SCAN_BLANK;
      idx_reg        <= '0;
      armed_reg      <= 1'b0;
      pend_dig_reg   <= '0;
      pend_err_reg   <= '0;
      act_dig_reg    <= '0;
      act_err_reg    <= '0;
      bcd_reg        <= '0;
      err_reg        <= 1'b0;
      dig_en_reg     <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      armed_reg      <= 1'b1;
      if (load) begin
        pend_dig_reg <= digits_in;
        pend_err_reg <= err_in;
      end
      act_dig_reg    <= act_dig_next;
      act_err_reg    <= act_err_next;
      bcd_reg        <= bcd_next;
      err_reg        <= err_next;
      dig_en_reg     <= dig_en_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bcd_out    = bcd_reg;
  assign err_out    = err_reg;
  assign dig_en     = dig_en_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a cycle-position model checked every
// cycle plus directed literal expectations for each scenario.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DV    = 3;
  localparam int BL    = 2;
  localparam int P     = DV + BL;
  localparam int FRAME = N * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  err_in = '0;
  logic [3:0]  bcd_out;
  logic        err_out;
  logic [3:0]  dig_en;
  logic        frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(DV), .BLANK_CYCLES(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .err_in     (err_in),
    .bcd_out    (bcd_out),
    .err_out    (err_out),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   k;
  logic chk_en = 1'b0;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_perr, m_aerr;

  // k = number of edges since reset released; the interval after edge k is cycle k.
  always @(posedge clk) begin
    if (rst) begin
      k      <= 0;
      m_pend <= '0;
      m_perr <= '0;
      m_act  <= '0;
      m_aerr <= '0;
    end else begin
      k <= k + 1;
      if (load) begin
        m_pend <= digits_in;
        m_perr <= err_in;
      end
      if (k >= BL && ((k - BL) % FRAME) == 0) begin
        m_act  <= load ? digits_in : m_pend;
        m_aerr <= load ? err_in    : m_perr;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  function automatic void model_out(input int kk, input logic [15:0] ad, input logic [3:0] ae,
                                    output logic [3:0] e_en, output logic [3:0] e_bcd,
                                    output logic e_err, output logic e_fd);
    int u, pos, d;
    e_en = '0; e_bcd = '0; e_err = 1'b0; e_fd = 1'b0;
    if (kk > BL) begin
      u   = kk - BL - 1;
      pos = u % P;
      d   = (u / P) % N;
      if (pos < DV) begin
        e_en  = 4'b0001 << d;
        e_bcd = ad[d*4 +: 4];
        e_err = ae[d] | (e_bcd > 4'd9);
        e_fd  = (pos == DV - 1) && (d == N - 1);
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [3:0] e_en, e_bcd;
    logic       e_err, e_fd;
    if (chk_en) begin
      model_out(k, m_act, m_aerr, e_en, e_bcd, e_err, e_fd);
      check("model_dig_en", dig_en, e_en);
      check("model_bcd", bcd_out, e_bcd);
      check("model_err", err_out, e_err);
      check("model_frame_done", frame_done, e_fd);
    end
  end

  task automatic wait_k(input int target);
    int n = 0;
    while (k != target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cycle actual=%0d required=%0d", k, target);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] e);
    load = 1'b1; digits_in = d; err_in = e;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // reset release, no load
    wait_k(1);  check("s1_c1_en", dig_en, 0); check("s1_c1_bcd", bcd_out, 0);
    wait_k(2);  check("s1_c2_en", dig_en, 0);
    wait_k(3);  check("s1_c3_en", dig_en, 4'b0001); check("s1_c3_bcd", bcd_out, 0); check("s1_c3_err", err_out, 0);
    wait_k(19); check("s1_c19_fd", frame_done, 0);
    wait_k(20); check("s1_c20_fd", frame_done, 1);
    pulse_rst();

    // 1234 loaded before the first commit
    wait_k(1);  pulse_load(16'h1234, 4'b0000);
    wait_k(3);  check("s2_d0_en", dig_en, 4'b0001); check("s2_d0_bcd", bcd_out, 4);
    wait_k(6);  check("s2_gap_en", dig_en, 0); check("s2_gap_bcd", bcd_out, 0);
    wait_k(8);  check("s2_d1_en", dig_en, 4'b0010); check("s2_d1_bcd", bcd_out, 3);
    wait_k(13); check("s2_d2_en", dig_en, 4'b0100); check("s2_d2_bcd", bcd_out, 2);

    // 5678 loaded mid-frame shows only from the next frame
    pulse_load(16'h5678, 4'b0000);
    wait_k(18); check("s3_d3_en", dig_en, 4'b1000); check("s3_d3_bcd", bcd_out, 1);
    wait_k(23); check("s3_n0_bcd", bcd_out, 8);
    wait_k(28); check("s3_n1_bcd", bcd_out, 7);
    wait_k(38); check("s3_n3_en", dig_en, 4'b1000); check("s3_n3_bcd", bcd_out, 5);

    // out-of-range nibble and explicit error flag
    wait_k(40); pulse_load(16'h00A0, 4'b1000);
    wait_k(43); check("s4_d0_err", err_out, 0); check("s4_d0_bcd", bcd_out, 0);
    wait_k(48); check("s4_d1_err", err_out, 1); check("s4_d1_bcd", bcd_out, 4'hA);
    wait_k(53); check("s4_d2_err", err_out, 0);
    wait_k(58); check("s4_d3_err", err_out, 1); check("s4_d3_en", dig_en, 4'b1000);

    // load exactly on the commit cycle
    wait_k(62); check("s5_commit_en", dig_en, 0);
    pulse_load(16'h9999, 4'b0000);
    check("s5_bypass_en", dig_en, 4'b0001); check("s5_bypass_bcd", bcd_out, 9); check("s5_bypass_err", err_out, 0);
    wait_k(68); check("s5_d1_bcd", bcd_out, 9);
    wait_k(83); check("s5_pend_en", dig_en, 4'b0001); check("s5_pend_bcd", bcd_out, 9);

    // reset during digit 2
    wait_k(94); check("s6_d2_en", dig_en, 4'b0100);
    pulse_rst();
    check("s6_rst_en", dig_en, 0); check("s6_rst_bcd", bcd_out, 0);
    check("s6_rst_err", err_out, 0); check("s6_rst_fd", frame_done, 0);
    wait_k(2);  check("s6_c2_en", dig_en, 0);
    wait_k(3);  check("s6_c3_en", dig_en, 4'b0001); check("s6_c3_bcd", bcd_out, 0);
    wait_k(8);  check("s6_d1_bcd", bcd_out, 0);
    wait_k(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
